// File: rtl/mem_dma_pkg.sv
// Shared definitions for the block-transfer engine and the 16k x 8 RAM wrapper.
package mem_dma_pkg;
  localparam int RAM_ADDR_W = 14;
  localparam int RAM_DATA_W = 8;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;
endpackage

// File: rtl/mem_dma_ptr.sv
// Wrapping address pointer / byte counter with load and single-step (up or down).
module mem_dma_ptr #(
  parameter int W    = 14,
  parameter bit DOWN = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_step,
  output logic [W-1:0] o_val
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val <= '0;
    end else if (i_load) begin
      r_val <= i_load_val;
    end else if (i_step) begin
      r_val <= DOWN ? (r_val - ONE) : (r_val + ONE);
    end
  end

  assign o_val = r_val;
endmodule

// File: rtl/mem_dma.sv
// Block-transfer engine (copy / fill) driving a synchronous-write, async-read RAM.
// Define MEM_DMA_CKSUM_EN to build the 8-bit running checksum of written bytes.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              START,
  input  logic              MODE,
  input  logic [ADDR_W-1:0] SRC,
  input  logic [ADDR_W-1:0] DST,
  input  logic [ADDR_W-1:0] LEN,
  input  logic [DATA_W-1:0] FILL_VAL,
  input  logic              ABORT,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] COUNT,
  output logic [DATA_W-1:0] CKSUM,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_WE,
  output logic              RAM_CS,
  output logic [DATA_W-1:0] RAM_DI,
  input  logic [DATA_W-1:0] RAM_DO
);
  state_t              r_state;
  state_t              w_next;
  logic                r_mode;
  logic [DATA_W-1:0]   r_fill;
  logic [DATA_W-1:0]   r_data;
  logic [ADDR_W-1:0]   r_count;
  logic                w_load;
  logic                w_rd;
  logic                w_wr;
  logic [ADDR_W-1:0]   w_src;
  logic [ADDR_W-1:0]   w_dst;
  logic [ADDR_W-1:0]   w_rem;

  assign w_load = (r_state == IDLE) && START;
  assign w_rd   = (r_state == RD);
  assign w_wr   = (r_state == WR);

  mem_dma_ptr #(.W(ADDR_W), .DOWN(1'b0)) u_src (
    .clk(clk), .rst(rst), .i_load(w_load), .i_load_val(SRC), .i_step(w_rd), .o_val(w_src)
  );
  mem_dma_ptr #(.W(ADDR_W), .DOWN(1'b0)) u_dst (
    .clk(clk), .rst(rst), .i_load(w_load), .i_load_val(DST), .i_step(w_wr), .o_val(w_dst)
  );
  mem_dma_ptr #(.W(ADDR_W), .DOWN(1'b1)) u_rem (
    .clk(clk), .rst(rst), .i_load(w_load), .i_load_val(LEN), .i_step(w_wr), .o_val(w_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= MODE_COPY;
      r_fill  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_mode  <= MODE;
        r_fill  <= FILL_VAL;
        r_count <= '0;
      end else if (w_wr) begin
        r_count <= r_count + ADDR_W'(1);
      end
    end
  end

  // Read data is consumed straight from the RAM's combinational output in RD.
  always_ff @(posedge clk) begin
    if (w_rd) begin
      r_data <= RAM_DO;
    end
  end

  assign COUNT = r_count;

`ifdef MEM_DMA_CKSUM_EN
  logic [DATA_W-1:0] r_cksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cksum <= '0;
    end else if (w_load) begin
      r_cksum <= '0;
    end else if (w_wr) begin
      r_cksum <= r_cksum + RAM_DI;
    end
  end

  assign CKSUM = r_cksum;
`else
  assign CKSUM = '0;
`endif

  always_comb begin
    w_next   = r_state;
    BUSY     = 1'b1;
    DONE     = 1'b0;
    RAM_CS   = 1'b0;
    RAM_WE   = 1'b0;
    RAM_ADDR = '0;
    RAM_DI   = '0;
    case (r_state)
      IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          if (LEN == '0)             w_next = FIN;
          else if (MODE == MODE_COPY) w_next = RD;
          else                        w_next = WR;
        end
      end
      RD: begin
        RAM_CS   = 1'b1;
        RAM_ADDR = w_src;
        w_next   = ABORT ? FIN : WR;
      end
      WR: begin
        RAM_CS   = 1'b1;
        RAM_WE   = 1'b1;
        RAM_ADDR = w_dst;
        RAM_DI   = (r_mode == MODE_FILL) ? r_fill : r_data;
        // An aborted WR still lands its byte; only the follow-on cycle is cut.
        if (ABORT || (w_rem == ADDR_W'(1))) w_next = FIN;
        else if (r_mode == MODE_COPY)       w_next = RD;
        else                                w_next = WR;
      end
      FIN: begin
        DONE   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: doc/mem_dma.md
# mem_dma

Block-transfer engine sitting directly upstream of the 16k x 8 synchronous-write/asynchronous-read RAM. It drives the RAM's address, write-enable, chip-select and write-data pins, and reads its data-out pins, to perform memory-to-memory copies and constant fills without CPU involvement. While BUSY is high the parent muxes RAM pins from this block; while BUSY is low it leaves the RAM deselected.

## Interface
- ADDR_W, 14, RAM address width; addresses and length are modulo 2^ADDR_W.
- DATA_W, 8, RAM data width.
- clk  in  1  rising-edge clock shared with the RAM.
- rst  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle request; sampled only in IDLE.
- MODE  in  1  0 = copy SRC→DST, 1 = fill DST with FILL_VAL.
- SRC  in  ADDR_W  copy source base address.
- DST  in  ADDR_W  destination base address.
- LEN  in  ADDR_W  byte count; 0 = no transfer.
- FILL_VAL  in  DATA_W  fill byte.
- ABORT  in  1  terminate the transfer early.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse on completion or abort.
- COUNT  out  ADDR_W  bytes written by the current/last transfer.
- CKSUM  out  DATA_W  see Configuration.
- RAM_ADDR  out  ADDR_W, RAM_WE  out  1, RAM_CS  out  1, RAM_DI  out  DATA_W, RAM_DO  in  DATA_W  RAM pins, active-high CS/WE.

## Operation
- States: IDLE, RD, WR, FIN.
- IDLE: START=1 at an edge latches SRC, DST, LEN, MODE and FILL_VAL; clears COUNT and CKSUM.
  - LEN=0 → FIN.
  - MODE=0 → RD.
  - MODE=1 → WR.
- RD (copy only): RAM_ADDR=src_ptr, RAM_CS=1, RAM_WE=0. At the edge, latch RAM_DO into the data register, increment src_ptr, go to WR.
- WR: RAM_ADDR=dst_ptr, RAM_CS=1, RAM_WE=1, RAM_DI = data register (copy) or FILL_VAL (fill). At the edge:
  - increment dst_ptr and COUNT; decrement remaining.
  - remaining==1 → FIN.
  - otherwise copy → RD, fill → WR.
- FIN: RAM_CS=0, DONE=1 for this cycle; next state is IDLE.
- Pointer increments wrap 16383→0. Copy is forward only; for overlapping regions with DST>SRC the result is the byte-by-byte forward result (defined, not memmove).
- ABORT=1 at an edge in RD or WR → FIN.
  - A WR cycle in which ABORT is sampled still completes its write and counts it.
  - An RD cycle's read is discarded.
  - ABORT is ignored in IDLE and FIN.
- START while BUSY is ignored; no queueing.
- Outside RD/WR: RAM_CS=0, RAM_WE=0, RAM_ADDR=0, RAM_DI=0.

## Timing
- Reset (async, any state): state=IDLE; BUSY, DONE, RAM_CS, RAM_WE=0; RAM_ADDR, RAM_DI, COUNT, CKSUM=0.
- Reset mid-transfer aborts with no DONE pulse. Bytes already written stay in RAM.
- START at edge N → BUSY high from cycle N+1.
- Copy of L bytes: 2L cycles of RD/WR, then 1 FIN cycle. DONE is high in cycle N+2L+1; BUSY falls at the following edge.
- Fill of L bytes: DONE in cycle N+L+1.
- LEN=0: DONE in cycle N+1.
- The RAM's combinational read path is consumed within the RD cycle. No extra wait state.

## Configuration
- MEM_DMA_CKSUM_EN defined: CKSUM accumulates the 8-bit wrap-around sum of every byte written (RAM_DI in each WR cycle). It is cleared on START and holds after DONE until the next START or reset.
- MEM_DMA_CKSUM_EN undefined: the accumulator logic is absent and CKSUM is tied to 0.

## Structure
- Shared package mem_dma_pkg holds:
  - state encoding enum (IDLE=0, RD=1, WR=2, FIN=3);
  - MODE_COPY/MODE_FILL constants;
  - default RAM_ADDR_W=14 and RAM_DATA_W=8, shared with the RAM wrapper.
- One natural sub-module: mem_dma_ptr. It is the wrapping address-pointer/counter with load and increment, instantiated for src_ptr, dst_ptr and remaining (down-count variant by parameter).

## Test plan
- Fill: DST=0x0100, LEN=4, FILL_VAL=0xA5 → RAM[0x100..0x103]=0xA5; DONE in cycle N+5; COUNT=4; CKSUM=0x94 when enabled.
- Copy: RAM[0x10..0x12]=11,22,33; SRC=0x10, DST=0x20, LEN=3 → RAM[0x20..0x22]=11,22,33; DONE in cycle N+7; RD/WR strictly alternate.
- Wrap: fill DST=0x3FFE, LEN=3, FILL_VAL=0x5A → RAM[0x3FFE], RAM[0x3FFF] and RAM[0x0000] = 0x5A; RAM[0x0001] untouched.
- Length zero / START while busy: LEN=0 → DONE at N+1, no RAM_CS. A second START during a copy → ignored; COUNT and destination reflect only the first request.
- Abort: copy LEN=8, ABORT sampled in the 3rd WR cycle → exactly 3 bytes written, COUNT=3, DONE the next cycle.
- Reset mid-copy: assert rst asynchronously mid-cycle → BUSY, RAM_CS and RAM_WE drop immediately; no DONE; a subsequent fill operates normally.
